pipelined_addsub: RTL
=====================

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4, range 8..64.
REQ-002 Parameter STAGES, default 2, pipeline depth; SHALL be 1..4 and divide WIDTH/4 evenly.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  operands and mode valid this cycle.
REQ-006 in_ready  output  1  block can accept a transaction this cycle.
REQ-007 in1  input  WIDTH  operand A.
REQ-008 in2  input  WIDTH  operand B.
REQ-009 sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result fields valid.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 out  output  WIDTH  result, registered.
REQ-013 carry  output  1  carry-out (add); not-borrow (sub: 1 when A >= B unsigned).
REQ-014 overflow  output  1  two's-complement signed overflow.
REQ-015 zero  output  1  out == 0.

Function
REQ-016 Transaction SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-017 Subtraction SHALL be computed as A + ~B + 1 (carry-in = sub); no separate subtractor.
REQ-018 Operand is split into STAGES segments of WIDTH/STAGES bits; stage s SHALL compute segment s using the registered carry from stage s-1; unused upper operand bits and completed lower result bits SHALL be carried forward in skew registers.
REQ-019 Latency SHALL be exactly STAGES cycles: accepted at edge k -> out_valid=1 with result after edge k+STAGES, absent stall.
REQ-020 Throughput SHALL be one transaction per cycle when out_ready stays high.
REQ-021 Stall: when out_valid && !out_ready, the entire pipeline SHALL hold (no register updates), and in_ready SHALL be 0.
REQ-022 in_ready = !(out_valid && !out_ready); combinational, no bubble collapsing required.
REQ-023 Per-stage valid bits SHALL track bubbles; out_valid SHALL be 0 for cycles with no transaction at the last stage.
REQ-024 overflow = carry into MSB XOR carry out of MSB; zero computed from the final-stage result.
REQ-025 out, carry, overflow, zero SHALL stay stable while out_valid && !out_ready.
REQ-026 Results SHALL emerge in acceptance order; none dropped or duplicated.

Reset
REQ-027 With rst=1 at a rising edge, all stage valids, out_valid, out, carry, overflow, zero SHALL be 0 after that edge.
REQ-028 Reset mid-operation SHALL discard all in-flight transactions; no result of them SHALL appear after reset.
REQ-029 in_ready SHALL be 1 the cycle after reset deasserts.
REQ-030 rst SHALL take priority over in_valid and stall in the same cycle.

Structure
REQ-031 Shared package addsub_pkg SHALL hold default WIDTH/STAGES constants and a flags typedef {carry, overflow, zero}.
REQ-032 One sub-module cla_segment (parametrised N-bit carry-lookahead adder built from 4-bit CLA groups, with cin/cout/c_msb_in) SHALL be instantiated once per stage.
REQ-033 Parameter legality (REQ-001/002) SHALL be checked at elaboration.

Verification (WIDTH=16, STAGES=2 unless stated)
REQ-034 Add 0xFFFF+0x0001 -> after 2 cycles out=0x0000, carry=1, zero=1, overflow=0.
REQ-035 Add 0x7FFF+0x0001 -> out=0x8000, overflow=1, carry=0, zero=0; sub 0x0005-0x0007 -> out=0xFFFE, carry=0, overflow=0.
REQ-036 Stream 3 back-to-back adds, hold out_ready=0 three cycles at first out_valid -> in_ready=0, outputs frozen, all 3 results delivered in order once out_ready=1.
REQ-037 Assert rst one cycle with 2 transactions in flight -> out_valid=0, out=0 next cycle; no stale result ever appears.
REQ-038 WIDTH=32, STAGES=4, 1000 random add/sub with random in_valid/out_ready -> every result matches reference model, latency 4 unstalled.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   DEFAULT_WIDTH  : default operand/result width in bits
//   DEFAULT_STAGES : default number of pipeline stages
//   CLA_GROUP_W    : width of one carry-lookahead group
//   flags_t        : status flags that accompany a result
package addsub_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 2;
  localparam int CLA_GROUP_W    = 4;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } flags_t;

endpackage

// File: rtl/cla_segment.sv
// N-bit carry-lookahead adder segment. It is built from 4-bit lookahead
// groups, and the group carries ripple from one group to the next.
// Ports:
//   a, b      : N-bit addends
//   cin       : carry into bit 0
//   sum       : N-bit sum
//   cout      : carry out of bit N-1
//   c_msb_in  : carry into bit N-1 (used for signed overflow)
module cla_segment
  import addsub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  localparam int GROUPS = N / CLA_GROUP_W;

  if ((N % CLA_GROUP_W) != 0 || N < CLA_GROUP_W) begin : g_chk_n
    $error("cla_segment: N (%0d) must be a positive multiple of 4", N);
  end

  // Returns the carries into bits 1..4 of a 4-bit group, as {c4, c3, c2, c1}.
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic ci);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N:0]   carry_vec;

  assign gen  = a & b;
  assign prop = a ^ b;

  always_comb begin
    logic [3:0] grp_c;
    logic       run_c;
    carry_vec    = '0;
    carry_vec[0] = cin;
    run_c        = cin;
    for (int i = 0; i < GROUPS; i++) begin
      grp_c = cla4(gen[i*CLA_GROUP_W +: CLA_GROUP_W], prop[i*CLA_GROUP_W +: CLA_GROUP_W], run_c);
      carry_vec[i*CLA_GROUP_W+1 +: CLA_GROUP_W] = grp_c;
      run_c = grp_c[3];
    end
  end

  assign sum      = prop ^ carry_vec[N-1:0];
  assign cout     = carry_vec[N];
  assign c_msb_in = carry_vec[N-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor with a valid/ready handshake at both ends.
// An accepted operand pair enters the stage-0 registers. Each of the STAGES
// stages adds one WIDTH/STAGES-bit segment using the carry registered by
// the previous stage. The result register updates STAGES edges after
// acceptance. When the output is stalled, the whole pipeline freezes.
// Ports:
//   clk, rst            : clock; synchronous active-high reset
//   in_valid / in_ready : input handshake
//   in1, in2, sub       : operands; sub=1 computes in1 - in2
//   out_valid/out_ready : output handshake
//   out                 : registered result
//   carry               : carry-out (add) / not-borrow (sub)
//   overflow, zero      : signed overflow; result equals zero
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if ((WIDTH % 4) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_chk_width
    $error("pipelined_addsub: WIDTH (%0d) must be a multiple of 4 in 8..64", WIDTH);
  end
  if (STAGES < 1 || STAGES > 4) begin : g_chk_stages
    $error("pipelined_addsub: STAGES (%0d) must be in 1..4", STAGES);
  end else if (((WIDTH / 4) % STAGES) != 0) begin : g_chk_div
    $error("pipelined_addsub: STAGES (%0d) must divide WIDTH/4 (%0d)", STAGES, WIDTH / 4);
  end

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return ~|v;
  endfunction

  // One stall signal gates every register, so no bubble is ever collapsed.
  logic advance;
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // wa_p[s] holds the completed result in bits below s*SEG and operand A
  // in the bits above. wb_p[s] carries operand B, already inverted for a
  // subtraction.
  logic [STAGES-1:0]            vld_p;
  logic [STAGES-1:0][WIDTH-1:0] wa_p;
  logic [STAGES-1:0][WIDTH-1:0] wb_p;
  logic [STAGES-1:0]            c_p;
  logic [STAGES-1:0][WIDTH-1:0] wa_nxt;
  logic [STAGES-1:0][SEG-1:0]   seg_sum;
  logic [STAGES-1:0]            seg_cout;
  logic [STAGES-1:0]            seg_cmsb;
  flags_t                       flags_q;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    cla_segment #(.N(SEG)) u_seg (
      .a        (wa_p[s][s*SEG +: SEG]),
      .b        (wb_p[s][s*SEG +: SEG]),
      .cin      (c_p[s]),
      .sum      (seg_sum[s]),
      .cout     (seg_cout[s]),
      .c_msb_in (seg_cmsb[s])
    );
  end

  always_comb begin
    wa_nxt = wa_p;
    for (int s = 0; s < STAGES; s++) begin
      wa_nxt[s][s*SEG +: SEG] = seg_sum[s];
    end
  end

  // Only the last stage's carry into the MSB is meaningful, and the last
  // stage's B register is consumed only in its own segment.
  logic unused_bits;
  assign unused_bits = ^{seg_cmsb, wb_p[LAST]};

  // ---- stage 0 capture / stage s -> s+1 skew registers (data, no reset) ----
  always_ff @(posedge clk) begin
    if (advance) begin
      wa_p[0] <= in1;
      wb_p[0] <= in2 ^ {WIDTH{sub}};
      c_p[0]  <= sub;
      for (int s = 1; s < STAGES; s++) begin
        wa_p[s] <= wa_nxt[s-1];
        wb_p[s] <= wb_p[s-1];
        c_p[s]  <= seg_cout[s-1];
      end
    end
  end

  // ---- valid chain and final-stage output registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p     <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      flags_q   <= '0;
    end else if (advance) begin
      vld_p[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) begin
        vld_p[s] <= vld_p[s-1];
      end
      out_valid <= vld_p[LAST];
      out       <= wa_nxt[LAST];
      flags_q   <= '{carry:    seg_cout[LAST],
                     overflow: seg_cout[LAST] ^ seg_cmsb[LAST],
                     zero:     is_zero(wa_nxt[LAST])};
    end
  end

  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;
  assign zero     = flags_q.zero;

endmodule
